// File: rtl/machine_mode_types_1_11_pkg.sv
// Machine-mode (priv spec 1.11) types: trap sequencer state, event kinds,
// synchronous exception cause codes and the priority-encoder result bundle.
package machine_mode_types_1_11_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StCommit,
        StRedirect
    } trap_state_t;

    typedef enum logic [1:0] {
        KindExc,
        KindIntr,
        KindRet
    } trap_kind_t;

    localparam logic [30:0] CauseInsnMisaligned  = 31'd0;
    localparam logic [30:0] CauseInsnFault       = 31'd1;
    localparam logic [30:0] CauseIllegalInsn     = 31'd2;
    localparam logic [30:0] CauseBreakpoint      = 31'd3;
    localparam logic [30:0] CauseLoadMisaligned  = 31'd4;
    localparam logic [30:0] CauseLoadFault       = 31'd5;
    localparam logic [30:0] CauseStoreMisaligned = 31'd6;
    localparam logic [30:0] CauseStoreFault      = 31'd7;
    localparam logic [30:0] CauseEcallM          = 31'd11;

    typedef struct packed {
        logic        valid;
        logic [30:0] cause;
        logic        is_ext;
    } trap_pri_t;

    // Width of the extension index; kept at least 1 so a single extension
    // still gets a legal port.
    function automatic int unsigned ext_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Interrupts, breakpoints and ecall carry no trap value. Extension codes
    // are excluded so a small RMGMT_CAUSE_BASE cannot alias 3 or 11.
    function automatic logic mtval_is_zero(trap_kind_t kind, logic [30:0] cause,
                                           logic is_ext);
        return (kind == KindIntr) ||
               (!is_ext && ((cause == CauseBreakpoint) || (cause == CauseEcallM)));
    endfunction

endpackage

// File: rtl/rv32i_types_pkg.sv
// Base RV32I types shared across the core.
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/prv_trap_priority.sv
// Combinational priority encoder for synchronous exceptions.
// Ports:
//   fault_insn .. fault_s : individual exception flags
//   ex_rmgmt, ex_rmgmt_cause : resource-management extension exception + index
//   pri : {valid, cause[30:0], is_ext} of the highest-priority flag
module prv_trap_priority
    import machine_mode_types_1_11_pkg::*;
#(
    parameter int unsigned NUM_EXTENSIONS   = 2,
    parameter int unsigned RMGMT_CAUSE_BASE = 24
) (
    input  logic                                 fault_insn,
    input  logic                                 mal_insn,
    input  logic                                 illegal_insn,
    input  logic                                 breakpoint,
    input  logic                                 env_m,
    input  logic                                 mal_l,
    input  logic                                 fault_l,
    input  logic                                 mal_s,
    input  logic                                 fault_s,
    input  logic                                 ex_rmgmt,
    input  logic [ext_width(NUM_EXTENSIONS)-1:0] ex_rmgmt_cause,
    output trap_pri_t                            pri
);

    always_comb begin
        pri        = '0;
        pri.valid  = 1'b1;
        if (fault_insn) begin
            pri.cause = CauseInsnFault;
        end else if (mal_insn) begin
            pri.cause = CauseInsnMisaligned;
        end else if (illegal_insn) begin
            pri.cause = CauseIllegalInsn;
        end else if (breakpoint) begin
            pri.cause = CauseBreakpoint;
        end else if (env_m) begin
            pri.cause = CauseEcallM;
        end else if (mal_l) begin
            pri.cause = CauseLoadMisaligned;
        end else if (fault_l) begin
            pri.cause = CauseLoadFault;
        end else if (mal_s) begin
            pri.cause = CauseStoreMisaligned;
        end else if (fault_s) begin
            pri.cause = CauseStoreFault;
        end else if (ex_rmgmt) begin
            pri.cause  = 31'(RMGMT_CAUSE_BASE) + 31'(ex_rmgmt_cause);
            pri.is_ext = 1'b1;
        end else begin
            pri.valid = 1'b0;
        end
    end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Machine-mode trap entry / mret sequencer.
// Picks one event in IDLE (exception > enabled interrupt > mret), drains the
// pipeline, commits trap CSRs in a single cycle and redirects fetch.
// Ports:
//   CLK, nRST                : clock, asynchronous active-low reset
//   exception flags, ex_rmgmt*: synchronous exceptions from the pipeline
//   ret                      : mret reached writeback
//   epc, badaddr             : PC and trap value to save
//   intr_req, intr_cause     : pending+enabled interrupt and its code
//   mie_global, mtvec, mepc  : current CSR state
//   pipe_clear               : pipeline is empty
//   flush_req                : drain request (DRAIN/COMMIT/REDIRECT)
//   insert_pc, priv_pc       : fetch redirect strobe and target
//   m*_we, m*_wdata          : CSR writes, one cycle in COMMIT
//   mstatus_push/pop         : MIE/MPIE stack operations
//   intr                     : interrupt-taken pulse
//   busy                     : sequencer not idle
// All outputs decode from registered state only.
module prv_trap_sequencer
    import rv32i_types_pkg::*;
    import machine_mode_types_1_11_pkg::*;
#(
    parameter int unsigned NUM_EXTENSIONS   = 2,
    parameter int unsigned RMGMT_CAUSE_BASE = 24
) (
    input  logic                                 CLK,
    input  logic                                 nRST,
    input  logic                                 fault_insn,
    input  logic                                 mal_insn,
    input  logic                                 illegal_insn,
    input  logic                                 breakpoint,
    input  logic                                 env_m,
    input  logic                                 mal_l,
    input  logic                                 fault_l,
    input  logic                                 mal_s,
    input  logic                                 fault_s,
    input  logic                                 ex_rmgmt,
    input  logic [ext_width(NUM_EXTENSIONS)-1:0] ex_rmgmt_cause,
    input  logic                                 ret,
    input  word_t                                epc,
    input  word_t                                badaddr,
    input  logic                                 intr_req,
    input  logic [4:0]                           intr_cause,
    input  logic                                 mie_global,
    input  word_t                                mtvec,
    input  word_t                                mepc,
    input  logic                                 pipe_clear,
    output logic                                 flush_req,
    output logic                                 insert_pc,
    output word_t                                priv_pc,
    output logic                                 mepc_we,
    output logic                                 mcause_we,
    output logic                                 mtval_we,
    output word_t                                mepc_wdata,
    output word_t                                mcause_wdata,
    output word_t                                mtval_wdata,
    output logic                                 mstatus_push,
    output logic                                 mstatus_pop,
    output logic                                 intr,
    output logic                                 busy
);

    trap_pri_t   pri;
    trap_state_t state_q, state_d;
    trap_kind_t  kind_q, kind_d;
    logic [30:0] cause_q, cause_d;
    logic        ext_q, ext_d;
    word_t       epc_q, epc_d;
    word_t       badaddr_q, badaddr_d;
    word_t       trap_target;

    prv_trap_priority #(
        .NUM_EXTENSIONS   (NUM_EXTENSIONS),
        .RMGMT_CAUSE_BASE (RMGMT_CAUSE_BASE)
    ) u_priority (
        .fault_insn     (fault_insn),
        .mal_insn       (mal_insn),
        .illegal_insn   (illegal_insn),
        .breakpoint     (breakpoint),
        .env_m          (env_m),
        .mal_l          (mal_l),
        .fault_l        (fault_l),
        .mal_s          (mal_s),
        .fault_s        (fault_s),
        .ex_rmgmt       (ex_rmgmt),
        .ex_rmgmt_cause (ex_rmgmt_cause),
        .pri            (pri)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= StIdle;
            kind_q    <= KindExc;
            cause_q   <= '0;
            ext_q     <= 1'b0;
            epc_q     <= '0;
            badaddr_q <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cause_q   <= cause_d;
            ext_q     <= ext_d;
            epc_q     <= epc_d;
            badaddr_q <= badaddr_d;
        end
    end

    // Next state. Events are only sampled in IDLE; a level interrupt that
    // arrives mid-sequence stays pending and is seen once we return here.
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cause_d   = cause_q;
        ext_d     = ext_q;
        epc_d     = epc_q;
        badaddr_d = badaddr_q;
        unique case (state_q)
            StIdle: begin
                if (pri.valid) begin
                    kind_d  = KindExc;
                    cause_d = pri.cause;
                    ext_d   = pri.is_ext;
                    state_d = StDrain;
                end else if (intr_req && mie_global) begin
                    kind_d  = KindIntr;
                    cause_d = {26'b0, intr_cause};
                    ext_d   = 1'b0;
                    state_d = StDrain;
                end else if (ret) begin
                    kind_d  = KindRet;
                    cause_d = '0;
                    ext_d   = 1'b0;
                    state_d = StDrain;
                end
                if (state_d == StDrain) begin
                    epc_d     = epc;
                    badaddr_d = badaddr;
                end
            end
            StDrain: begin
                if (pipe_clear) begin
                    state_d = StCommit;
                end
            end
            StCommit:   state_d = StRedirect;
            StRedirect: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Vectored mode (mtvec[1:0] == 01) offsets interrupts only.
    always_comb begin
        trap_target = {mtvec[31:2], 2'b00};
        if ((mtvec[1:0] == 2'b01) && (kind_q == KindIntr)) begin
            trap_target = trap_target + {25'b0, cause_q[4:0], 2'b00};
        end
    end

    always_comb begin
        flush_req    = 1'b0;
        insert_pc    = 1'b0;
        priv_pc      = '0;
        mepc_we      = 1'b0;
        mcause_we    = 1'b0;
        mtval_we     = 1'b0;
        mepc_wdata   = '0;
        mcause_wdata = '0;
        mtval_wdata  = '0;
        mstatus_push = 1'b0;
        mstatus_pop  = 1'b0;
        intr         = 1'b0;
        busy         = (state_q != StIdle);
        unique case (state_q)
            StIdle: ;
            StDrain: flush_req = 1'b1;
            StCommit: begin
                flush_req = 1'b1;
                if (kind_q == KindRet) begin
                    mstatus_pop = 1'b1;
                end else begin
                    mepc_we      = 1'b1;
                    mcause_we    = 1'b1;
                    mtval_we     = 1'b1;
                    mstatus_push = 1'b1;
                    intr         = (kind_q == KindIntr);
                    mepc_wdata   = epc_q;
                    mcause_wdata = {kind_q == KindIntr, cause_q};
                    mtval_wdata  = mtval_is_zero(kind_q, cause_q, ext_q) ? '0 : badaddr_q;
                end
            end
            StRedirect: begin
                flush_req = 1'b1;
                insert_pc = 1'b1;
                priv_pc   = (kind_q == KindRet) ? mepc : trap_target;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_prv_trap_sequencer.sv
module tb_prv_trap_sequencer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [8:0]  exc;  // {fault_s,mal_s,fault_l,mal_l,env_m,breakpoint,illegal,mal_insn,fault_insn}
    logic        ex_rmgmt;
    logic [0:0]  ex_rmgmt_cause;
    logic        ret;
    logic [31:0] epc, badaddr, mtvec, mepc;
    logic        intr_req, mie_global, pipe_clear;
    logic [4:0]  intr_cause;
    logic        flush_req, insert_pc, mepc_we, mcause_we, mtval_we;
    logic        mstatus_push, mstatus_pop, intr, busy;
    logic [31:0] priv_pc, mepc_wdata, mcause_wdata, mtval_wdata;

    typedef struct {
        logic        is_ret;
        logic        is_intr;
        logic [31:0] mcause;
        logic [31:0] mepc;
        logic [31:0] mtval;
        logic [31:0] target;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    logic pend_valid = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    prv_trap_sequencer #(
        .NUM_EXTENSIONS   (2),
        .RMGMT_CAUSE_BASE (24)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .fault_insn     (exc[0]),
        .mal_insn       (exc[1]),
        .illegal_insn   (exc[2]),
        .breakpoint     (exc[3]),
        .env_m          (exc[4]),
        .mal_l          (exc[5]),
        .fault_l        (exc[6]),
        .mal_s          (exc[7]),
        .fault_s        (exc[8]),
        .ex_rmgmt       (ex_rmgmt),
        .ex_rmgmt_cause (ex_rmgmt_cause),
        .ret            (ret),
        .epc            (epc),
        .badaddr        (badaddr),
        .intr_req       (intr_req),
        .intr_cause     (intr_cause),
        .mie_global     (mie_global),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .pipe_clear     (pipe_clear),
        .flush_req      (flush_req),
        .insert_pc      (insert_pc),
        .priv_pc        (priv_pc),
        .mepc_we        (mepc_we),
        .mcause_we      (mcause_we),
        .mtval_we       (mtval_we),
        .mepc_wdata     (mepc_wdata),
        .mcause_wdata   (mcause_wdata),
        .mtval_wdata    (mtval_wdata),
        .mstatus_push   (mstatus_push),
        .mstatus_pop    (mstatus_pop),
        .intr           (intr),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic is_ret, input logic is_intr, input logic [31:0] mc,
                            input logic [31:0] me, input logic [31:0] mt,
                            input logic [31:0] tgt);
        exp_t e;
        e.is_ret = is_ret; e.is_intr = is_intr; e.mcause = mc;
        e.mepc = me; e.mtval = mt; e.target = tgt;
        sb.push_back(e);
    endtask

    // Counts falling edges until insert_pc is seen, bounded.
    task automatic wait_redirect(output int cyc);
        cyc = 0;
        while (insert_pc !== 1'b1 && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    // Called just after the posedge on which the event was driven: lets the
    // DUT sample it, clears one-shot inputs and checks the redirect latency.
    task automatic take(input string tag, input int exp_lat);
        int lat;
        @(posedge CLK); #1;
        exc = '0; ret = 1'b0; ex_rmgmt = 1'b0; intr_req = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_pc_idle"}, priv_pc, 32'd0);
        wait_redirect(lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        @(posedge CLK); #1;
    endtask

    // Scoreboard monitor: each commit pops one expectation; the following
    // redirect must match its target. A strobe lasting two cycles pops an
    // empty queue or finds no pending commit.
    initial begin
        exp_t cur;
        logic [5:0] exp_strobe;
        forever begin
            @(negedge CLK);
            if (mepc_we | mcause_we | mtval_we | mstatus_push | mstatus_pop | intr) begin
                if (sb.size() == 0) begin
                    check("commit_unexpected", 32'(sb.size()), 32'd1);
                end else begin
                    cur = sb.pop_front();
                    exp_strobe = cur.is_ret ? 6'b000010 : {5'b11110, cur.is_intr};
                    check("strobes", 32'({mepc_we, mcause_we, mtval_we, mstatus_push,
                                          mstatus_pop, intr}), 32'(exp_strobe));
                    if (!cur.is_ret) begin
                        check("mcause", mcause_wdata, cur.mcause);
                        check("mepc", mepc_wdata, cur.mepc);
                        check("mtval", mtval_wdata, cur.mtval);
                    end
                    pend = cur;
                    pend_valid = 1'b1;
                end
            end
            if (insert_pc) begin
                check("redirect_after_commit", 32'(pend_valid), 32'd1);
                check("priv_pc", priv_pc, pend.target);
                pend_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  tbl_flags [8];
        logic [31:0] tbl_code  [8];
        logic [31:0] mt;
        int          lat;

        tbl_flags[0] = 10'b00_0000_0111; tbl_code[0] = 1;   // fault_insn wins
        tbl_flags[1] = 10'b00_0000_1110; tbl_code[1] = 0;   // mal_insn
        tbl_flags[2] = 10'b00_0011_1000; tbl_code[2] = 3;   // breakpoint
        tbl_flags[3] = 10'b01_0011_0000; tbl_code[3] = 11;  // env_m
        tbl_flags[4] = 10'b00_0110_0000; tbl_code[4] = 4;   // mal_l
        tbl_flags[5] = 10'b00_1100_0000; tbl_code[5] = 5;   // fault_l
        tbl_flags[6] = 10'b01_1000_0000; tbl_code[6] = 6;   // mal_s
        tbl_flags[7] = 10'b11_0000_0000; tbl_code[7] = 7;   // fault_s over ex_rmgmt

        nRST = 1'b0; exc = '0; ex_rmgmt = 1'b0; ex_rmgmt_cause = '0; ret = 1'b0;
        epc = '0; badaddr = '0; mtvec = '0; mepc = '0; intr_req = 1'b0;
        intr_cause = '0; mie_global = 1'b0; pipe_clear = 1'b1;
        #3;
        check("reset_ctrl", 32'({flush_req, insert_pc, mepc_we, mcause_we, mtval_we,
                                 mstatus_push, mstatus_pop, intr, busy}), 32'd0);
        check("reset_data", priv_pc | mepc_wdata | mcause_wdata | mtval_wdata, 32'd0);
        @(posedge CLK); #1; nRST = 1'b1;
        @(posedge CLK); #1;

        // illegal_insn + mal_l: illegal wins
        exc[2] = 1'b1; exc[5] = 1'b1; epc = 32'h100; badaddr = 32'h2003;
        mtvec = 32'h8000_0000;
        push_exp(1'b0, 1'b0, 32'd2, 32'h100, 32'h2003, 32'h8000_0000);
        take("illegal", 3);

        // Vectored interrupt
        intr_req = 1'b1; intr_cause = 5'd7; mie_global = 1'b1; mtvec = 32'h8000_0001;
        epc = 32'h200; badaddr = 32'hDEAD;
        push_exp(1'b0, 1'b1, 32'h8000_0007, 32'h200, 32'd0, 32'h8000_001C);
        take("intr7", 3);

        // Exception priority table; vectored mtvec must not offset exceptions
        mtvec = 32'h0000_1001;
        for (int i = 0; i < 8; i++) begin
            exc = tbl_flags[i][8:0]; ex_rmgmt = tbl_flags[i][9];
            epc = 32'h1000_0000 + 32'(i * 4); badaddr = 32'hB000 + 32'(i);
            mt = (tbl_code[i] == 3 || tbl_code[i] == 11) ? 32'd0 : badaddr;
            push_exp(1'b0, 1'b0, tbl_code[i], epc, mt, 32'h0000_1000);
            take("prio", 3);
        end

        // Extension exception, index 1
        ex_rmgmt = 1'b1; ex_rmgmt_cause = 1'b1; epc = 32'h500; badaddr = 32'h55;
        push_exp(1'b0, 1'b0, 32'd25, 32'h500, 32'h55, 32'h0000_1000);
        take("rmgmt", 3);

        // fault_s and interrupt together: exception first, interrupt in next IDLE
        mtvec = 32'h8000_0001; exc[8] = 1'b1; intr_req = 1'b1; intr_cause = 5'd3;
        epc = 32'h300; badaddr = 32'h77;
        push_exp(1'b0, 1'b0, 32'd7, 32'h300, 32'h77, 32'h8000_0000);
        push_exp(1'b0, 1'b1, 32'h8000_0003, 32'h304, 32'd0, 32'h8000_000C);
        @(posedge CLK); #1;
        exc = '0; epc = 32'h304; badaddr = 32'h88;
        wait_redirect(lat);
        check("both_exc_latency", 32'(lat), 32'd3);
        @(posedge CLK); #1;
        check("both_idle_gap", 32'(busy), 32'd0);
        @(posedge CLK); #1;
        intr_req = 1'b0;
        check("both_intr_busy", 32'(busy), 32'd1);
        wait_redirect(lat);
        check("both_intr_latency", 32'(lat), 32'd3);
        @(posedge CLK); #1;

        // Interrupt masked by mie_global: ignored
        intr_req = 1'b1; mie_global = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("masked_idle", 32'(busy), 32'd0);
        end

        // mret with slow drain; masked interrupt still pending
        @(posedge CLK); #1;
        ret = 1'b1; mepc = 32'h4444; pipe_clear = 1'b0;
        push_exp(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'h4444);
        @(posedge CLK); #1;
        ret = 1'b0; intr_req = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            check("ret_flush", 32'(flush_req), 32'd1);
            check("ret_no_pop", 32'(mstatus_pop), 32'd0);
        end
        pipe_clear = 1'b1;
        wait_redirect(lat);
        check("ret_latency", 32'(lat), 32'd2);
        @(posedge CLK); #1;

        // Reset during DRAIN aborts the sequence
        exc[2] = 1'b1; pipe_clear = 1'b0; epc = 32'h600; badaddr = 32'h66;
        @(posedge CLK); #1;
        exc = '0;
        check("rst_pre_busy", 32'(busy), 32'd1);
        nRST = 1'b0;
        #1;
        check("rst_mid_ctrl", 32'({flush_req, insert_pc, mepc_we, mcause_we, mtval_we,
                                   mstatus_push, mstatus_pop, intr, busy}), 32'd0);
        check("rst_mid_data", priv_pc | mepc_wdata | mcause_wdata | mtval_wdata, 32'd0);
        repeat (2) @(posedge CLK);
        #1; nRST = 1'b1; pipe_clear = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("rst_after_idle", 32'(busy), 32'd0);
        end

        // Recovery after reset
        @(posedge CLK); #1;
        exc[0] = 1'b1; mtvec = 32'h0000_2000; epc = 32'h700; badaddr = 32'h71;
        push_exp(1'b0, 1'b0, 32'd1, 32'h700, 32'h71, 32'h0000_2000);
        take("recover", 3);

        repeat (2) @(negedge CLK);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
